// File: rtl/tpu_pkg.sv
// Shared address map, CTRL/STATUS bit positions and FSM encoding for the TPU host front end.
package tpu_pkg;

  localparam logic [3:0] ADDR_A0     = 4'd0;
  localparam logic [3:0] ADDR_B0     = 4'd4;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;
  localparam logic [3:0] ADDR_C0     = 4'd12;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_ERR     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } tpu_state_e;

endpackage

// File: rtl/tpu_watchdog.sv
// Run watchdog: counter cleared on start, counts while enabled, flags the last allowed cycle.
module tpu_watchdog #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/tpu_mmio_ctrl.sv
// Register-mapped host front end for tpu_top: operand registers, run FSM with watchdog,
// result capture, status and a completion interrupt.
module tpu_mmio_ctrl
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_SIZE      = 8,
  parameter int DIM_SIZE       = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [3:0]            addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] rowA0,
  output logic [DATA_WIDTH-1:0] rowA1,
  output logic [DATA_WIDTH-1:0] rowA2,
  output logic [DATA_WIDTH-1:0] rowA3,
  output logic [DATA_WIDTH-1:0] colB0,
  output logic [DATA_WIDTH-1:0] colB1,
  output logic [DATA_WIDTH-1:0] colB2,
  output logic [DATA_WIDTH-1:0] colB3,
  output logic                  go_bit,
  input  logic                  done_bit,
  input  logic [DATA_WIDTH-1:0] rowC0,
  input  logic [DATA_WIDTH-1:0] rowC1,
  input  logic [DATA_WIDTH-1:0] rowC2,
  input  logic [DATA_WIDTH-1:0] rowC3,
  output tpu_state_e            state_dbg
);

  if (DATA_WIDTH != DATA_SIZE * DIM_SIZE || DIM_SIZE != 4) begin : g_bad_geometry
    $error("tpu_mmio_ctrl: DATA_WIDTH must equal DATA_SIZE*DIM_SIZE with DIM_SIZE=4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("tpu_mmio_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  logic [DATA_WIDTH-1:0] a_q [4];
  logic [DATA_WIDTH-1:0] b_q [4];
  logic [DATA_WIDTH-1:0] c_q [4];
  logic [DATA_WIDTH-1:0] c_in [4];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [3:0]            status;
  logic                  done_q, timeout_q, err_q;
  tpu_state_e            state_q, state_d;
  logic                  wd_clr, wd_en, wd_expire;
  logic                  busy, is_a, is_b, is_c, is_ctrl, is_status;
  logic                  start_req, start_ok, clear_req, op_wr, cap_done, cap_timeout;

  assign c_in[0] = rowC0;
  assign c_in[1] = rowC1;
  assign c_in[2] = rowC2;
  assign c_in[3] = rowC3;

  // FINISH still counts as busy so operands cannot change until the FSM is back in IDLE.
  assign busy      = (state_q != IDLE);
  assign is_a      = (addr[3:2] == ADDR_A0[3:2]);
  assign is_b      = (addr[3:2] == ADDR_B0[3:2]);
  assign is_c      = (addr[3:2] == ADDR_C0[3:2]);
  assign is_ctrl   = (addr == ADDR_CTRL);
  assign is_status = (addr == ADDR_STATUS);

  assign start_req   = wr_en && is_ctrl && wdata[CTRL_START];
  assign clear_req   = wr_en && is_ctrl && wdata[CTRL_CLEAR];
  assign op_wr       = wr_en && (is_a || is_b);
  assign start_ok    = start_req && (state_q == IDLE);
  assign cap_done    = (state_q == RUN) && done_bit;
  assign cap_timeout = (state_q == RUN) && !done_bit && wd_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go_bit  = 1'b0;
    irq     = 1'b0;
    wd_en   = 1'b0;
    wd_clr  = start_ok;
    unique case (state_q)
      IDLE: if (start_req) state_d = RUN;
      RUN: begin
        go_bit = 1'b1;
        wd_en  = 1'b1;
        if (done_bit || wd_expire) state_d = FINISH;
      end
      FINISH: begin
        irq     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state_q;

  tpu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Later statements win: clear first, then error flags, then run start/completion events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (clear_req) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        err_q     <= 1'b0;
      end
      if ((op_wr || start_req) && busy) err_q <= 1'b1;
      if (start_ok) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (cap_done) begin
        done_q <= 1'b1;
        for (int i = 0; i < 4; i++) c_q[i] <= c_in[i];
      end
      if (cap_timeout) timeout_q <= 1'b1;
      if (op_wr && !busy) begin
        if (is_a) a_q[addr[1:0]] <= wdata;
        else      b_q[addr[1:0]] <= wdata;
      end
    end
  end

  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = busy;
    status[STAT_DONE]    = done_q;
    status[STAT_TIMEOUT] = timeout_q;
    status[STAT_ERR]     = err_q;
  end

  always_comb begin
    rd_mux = '0;
    if (is_a)           rd_mux = a_q[addr[1:0]];
    else if (is_b)      rd_mux = b_q[addr[1:0]];
    else if (is_c)      rd_mux = c_q[addr[1:0]];
    else if (is_status) rd_mux = {{(DATA_WIDTH-4){1'b0}}, status};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

  assign rowA0 = a_q[0];
  assign rowA1 = a_q[1];
  assign rowA2 = a_q[2];
  assign rowA3 = a_q[3];
  assign colB0 = b_q[0];
  assign colB1 = b_q[1];
  assign colB2 = b_q[2];
  assign colB3 = b_q[3];

endmodule

// File: doc/tpu_mmio_ctrl.md
Name: tpu_mmio_ctrl

Overview:
Host-side front end that sits directly upstream of tpu_top. It gives the processor a small register-mapped interface for loading the packed A rows and B columns. It drives go_bit, waits for done_bit, latches rowC0..rowC3 into result registers and raises a completion interrupt. A watchdog aborts the run if done_bit never arrives.

Parameters:
DATA_WIDTH, 32, width of one packed row/column word (DIM_SIZE elements of DATA_SIZE bits)
DATA_SIZE, 8, element width; used only for documentation and checks (DATA_WIDTH must equal DATA_SIZE*DIM_SIZE)
DIM_SIZE, 4, matrix dimension; address map below is fixed for 4
TIMEOUT_CYCLES, 32, cycles allowed in RUN before abort; must be at least 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host write strobe, one word per cycle
rd_en  in  1  host read strobe
addr  in  4  host word address
wdata  in  DATA_WIDTH  host write data
rdata  out  DATA_WIDTH  read data, valid when rvalid=1
rvalid  out  1  one-cycle read-data valid
irq  out  1  one-cycle pulse on run completion or timeout
rowA0..rowA3  out  DATA_WIDTH each  A row registers to tpu_top
colB0..colB3  out  DATA_WIDTH each  B column registers to tpu_top
go_bit  out  1  run request to tpu_top
done_bit  in  1  completion from tpu_top
rowC0..rowC3  in  DATA_WIDTH each  result rows from tpu_top

Behaviour:
- Reset (async, rst_n=0): all A/B/C registers 0; rdata=0; rvalid=0; irq=0; go_bit=0; FSM=IDLE; status bits 0; watchdog=0.
- Address map:
  - 0-3: rowA0-3, R/W
  - 4-7: colB0-3, R/W
  - 8: CTRL, write-only. bit0=start, bit1=clear_status. Reads return 0.
  - 9: STATUS, read-only. bit0=busy, bit1=done, bit2=timeout, bit3=err.
  - 12-15: C0-C3 result registers, read-only.
  - 10, 11: reserved. Reads return 0; writes are ignored.
- Reads: rdata and rvalid are registered, so data appears exactly 1 cycle after rd_en. rvalid=0 and rdata holds its last value when no read is issued.
- A read issued in the same cycle as a write returns the pre-write value. Both operations complete.
- FSM has three states:
  - IDLE: busy=0.
  - RUN: go_bit=1 (held level), busy=1, watchdog increments every cycle.
  - FINISH: one cycle; go_bit=0, irq=1.
- IDLE -> RUN on a CTRL write with bit0=1. Same cycle: done and timeout clear, watchdog resets to 0.
- RUN -> FINISH when done_bit=1 is sampled. That same edge latches rowC0-3 into C0-C3 and sets done=1.
- RUN -> FINISH when the watchdog reaches TIMEOUT_CYCLES-1 with done_bit=0. Sets timeout=1; C registers are unchanged.
- If done_bit and the timeout coincide on the same edge, done wins: results are captured, timeout stays 0.
- FINISH -> IDLE unconditionally.
- done_bit=1 while in IDLE or FINISH is ignored.
- Writes to addresses 0-7 while busy=1 are dropped and set err=1. Operands stay stable for the whole run.
- A start while busy=1 is dropped and sets err=1.
- clear_status=1 clears done, timeout and err. If start=1 is in the same write, clear is applied first and then start is taken (when legal).
- Reset asserted mid-RUN drops go_bit asynchronously and returns to IDLE. No irq is generated.
- Latency from the start write to go_bit=1 is 1 cycle. go_bit deasserts on the edge after done_bit is sampled.

Decomposition:
- Shared package tpu_pkg holds:
  - address constants ADDR_A0, ADDR_B0, ADDR_CTRL, ADDR_STATUS, ADDR_C0
  - STATUS/CTRL bit indices
  - FSM state encoding (IDLE, RUN, FINISH)
- One natural sub-module: tpu_watchdog. It is a loadable counter with clear, enable and an expire output at TIMEOUT_CYCLES-1. Everything else stays in tpu_mmio_ctrl.

Test Plan:
1. Write A0-3 = 0x01020304 ... 0x0D0E0F10, B0-3 likewise, read back each -> rdata matches 1 cycle after rd_en, rvalid is a single-cycle pulse.
2. Start, with the model asserting done_bit 10 cycles later and rowC0-3 = 0xAAAA0000..0xAAAA0003 -> go_bit high 10 cycles, irq pulses once, C0-C3 read back exactly, STATUS=0x2.
3. Start with done_bit never asserted, TIMEOUT_CYCLES=32 -> go_bit drops after 32 cycles, irq pulses, STATUS=0x4, C registers unchanged from the previous run.
4. During RUN, write A1=0xFFFFFFFF and issue a second start -> rowA1 unchanged, no extra run, STATUS err bit set; then write CTRL=0x2 -> STATUS=0x0.
5. rst_n pulsed low mid-RUN -> go_bit=0 immediately, all registers read 0, no irq. A following start works normally.
6. done_bit and watchdog expiry on the same edge, plus a simultaneous read and write of A0 -> results captured, timeout=0, read returns the old A0 value.
